// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I fetch stage: FSM states, next-pc select
// encoding, default reset vector and the canonical NOP.
package riscv_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_TARGET
  } pc_sel_t;

  function automatic logic word_aligned(input logic [INSTR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter with its next-pc mux (hold / sequential +4 / redirect target).
// The +4 path wraps naturally at the top of the address space.
module fetch_pc_reg
  import riscv_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  pc_sel_t            pc_sel_i,
  input  logic [INSTR_W-1:0] target_i,
  output logic [INSTR_W-1:0] pc_o
);

  logic [INSTR_W-1:0] pc_q;
  logic [INSTR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel_i)
      PC_INC:    pc_d = pc_q + 32'd4;
      PC_TARGET: pc_d = target_i;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Single-issue RV32I instruction fetch: req/gnt + rvalid memory handshake, one held
// instruction toward decode, redirect with in-flight kill, sticky fault on misalignment/timeout.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                 MAX_WAIT = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] Instr,
  output logic [INSTR_W-1:0] PC,
  output logic [INSTR_W-1:0] PCPlus4,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               PCSrc,
  input  logic [INSTR_W-1:0] PCTarget,
  output logic               fetch_fault
);

  localparam int               CNT_W     = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  fetch_state_t       state_q, state_d;
  logic               kill_q, kill_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc_out_q, pc_out_d;
  logic               valid_q, valid_d;
  logic               fault_q, fault_d;
  pc_sel_t            pc_sel;
  logic [INSTR_W-1:0] pc;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .pc_sel_i (pc_sel),
    .target_i (PCTarget),
    .pc_o     (pc)
  );

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    wait_d   = wait_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    pc_sel   = PC_HOLD;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          wait_d  = '0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc;
            valid_d  = 1'b1;
            state_d  = S_HOLD;
          end
        end else if (wait_q >= WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_sel  = PC_INC;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_HALT: valid_d = 1'b0;
      default: state_d = S_HALT;
    endcase

    // Redirect overrides every transition above; only reset leaves S_HALT.
    if (PCSrc && (state_q != S_HALT)) begin
      valid_d  = 1'b0;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      if (!word_aligned(PCTarget)) begin
        fault_d = 1'b1;
        pc_sel  = PC_HOLD;
        state_d = S_HALT;
      end else begin
        pc_sel = PC_TARGET;
        unique case (state_q)
          S_REQ: begin
            if (imem_gnt) begin
              kill_d  = 1'b1;
              state_d = S_WAIT;
            end else begin
              state_d = S_REQ;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              // Keep waiting for the stale response so it can be discarded.
              fault_d = fault_q;
              kill_d  = 1'b1;
              state_d = S_WAIT;
            end
          end
          default: state_d = S_REQ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      kill_q   <= 1'b0;
      wait_q   <= '0;
      instr_q  <= '0;
      pc_out_q <= RESET_PC;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      wait_q   <= wait_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc;
  assign Instr       = instr_q;
  assign PC          = pc_out_q;
  assign PCPlus4     = pc_out_q + 32'd4;
  assign instr_valid = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: each task drives one scenario and checks outputs inline.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;
  logic        fetch_fault;

  int asserts  = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .fetch_fault (fetch_fault)
  );

  // Advance n clock edges; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    PCTarget    = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    step(2);
    reset = 1'b0;
  endtask

  // From S_REQ: grant immediately, return data next cycle; ends with the word held.
  task automatic serve(input logic [31:0] data);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    step(2);
    asserts++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    asserts++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    asserts++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
    asserts++; if (PC !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected %h", PC, 32'h0); end
    asserts++; if (PCPlus4 !== 32'h4) begin failures++; $display("FAIL reset_pcplus4: got %h expected %h", PCPlus4, 32'h4); end
    asserts++; if (Instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected %h", Instr, 32'h0); end
    reset = 1'b0;
    step();
    asserts++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req: got %b expected 1", imem_req); end
    asserts++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr: got %h expected %h", imem_addr, 32'h0); end
    $display("test_reset done");
  endtask

  task automatic test_basic_fetch();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    asserts++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wait_req: got %b expected 0", imem_req); end
    asserts++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL wait_valid: got %b expected 0", instr_valid); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    asserts++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", instr_valid); end
    asserts++; if (Instr !== 32'h0050_0093) begin failures++; $display("FAIL basic_instr: got %h expected %h", Instr, 32'h0050_0093); end
    asserts++; if (PC !== 32'h0) begin failures++; $display("FAIL basic_pc: got %h expected %h", PC, 32'h0); end
    asserts++; if (PCPlus4 !== 32'h4) begin failures++; $display("FAIL basic_pcplus4: got %h expected %h", PCPlus4, 32'h4); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    asserts++; if (imem_req !== 1'b1) begin failures++; $display("FAIL basic_next_req: got %b expected 1", imem_req); end
    asserts++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL basic_next_addr: got %h expected %h", imem_addr, 32'h4); end
    asserts++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL basic_consumed: got %b expected 0", instr_valid); end
    $display("test_basic_fetch done: addr 0 -> instr 00500093");
  endtask

  task automatic test_decode_stall();
    serve(32'h00a0_0113);
    for (int i = 0; i < 5; i++) begin
      asserts++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, instr_valid); end
      asserts++; if (Instr !== 32'h00a0_0113) begin failures++; $display("FAIL stall_instr[%0d]: got %h expected %h", i, Instr, 32'h00a0_0113); end
      asserts++; if (PC !== 32'h4) begin failures++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, PC, 32'h4); end
      asserts++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req); end
      step();
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    asserts++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL stall_next_addr: got %h expected %h", imem_addr, 32'h8); end
    asserts++; if (imem_req !== 1'b1) begin failures++; $display("FAIL stall_next_req: got %b expected 1", imem_req); end
    $display("test_decode_stall done: held pc 4 for 5 cycles");
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    PCSrc    = 1'b1;
    PCTarget = 32'h100;
    step();
    PCSrc = 1'b0;
    asserts++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rw_still_waiting: got %b expected 0", imem_req); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hdead_beef;
    step();
    imem_rvalid = 1'b0;
    asserts++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rw_dropped_valid: got %b expected 0", instr_valid); end
    asserts++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rw_req: got %b expected 1", imem_req); end
    asserts++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL rw_addr: got %h expected %h", imem_addr, 32'h100); end
    serve(32'h0010_0073);
    asserts++; if (Instr !== 32'h0010_0073) begin failures++; $display("FAIL rw_new_instr: got %h expected %h", Instr, 32'h0010_0073); end
    asserts++; if (PC !== 32'h100) begin failures++; $display("FAIL rw_new_pc: got %h expected %h", PC, 32'h100); end
    asserts++; if (PCPlus4 !== 32'h104) begin failures++; $display("FAIL rw_new_pcplus4: got %h expected %h", PCPlus4, 32'h104); end
    $display("test_redirect_wait done: target 100");
  endtask

  task automatic test_redirect_hold();
    instr_ready = 1'b1;
    PCSrc       = 1'b1;
    PCTarget    = 32'h200;
    step();
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    asserts++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rh_squash: got %b expected 0", instr_valid); end
    asserts++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL rh_addr: got %h expected %h", imem_addr, 32'h200); end
    asserts++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rh_req: got %b expected 1", imem_req); end
    serve(32'h00c0_0193);
    asserts++; if (PC !== 32'h200) begin failures++; $display("FAIL rh_pc: got %h expected %h", PC, 32'h200); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    asserts++; if (imem_addr !== 32'h204) begin failures++; $display("FAIL rh_next_addr: got %h expected %h", imem_addr, 32'h204); end
    $display("test_redirect_hold done: target 200");
  endtask

  task automatic test_timeout();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    step(15);
    asserts++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL to_early_fault: got %b expected 0", fetch_fault); end
    step();
    asserts++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL to_fault: got %b expected 1", fetch_fault); end
    asserts++; if (imem_req !== 1'b0) begin failures++; $display("FAIL to_req: got %b expected 0", imem_req); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    asserts++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL to_late_rvalid: got %b expected 0", instr_valid); end
    step(3);
    asserts++; if (imem_req !== 1'b0) begin failures++; $display("FAIL to_halt_req: got %b expected 0", imem_req); end
    reset = 1'b1;
    #1;
    asserts++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL to_async_clear: got %b expected 0", fetch_fault); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("test_timeout done: fault after 16 idle wait cycles");
  endtask

  task automatic test_misaligned();
    step();
    asserts++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL mis_start_addr: got %h expected %h", imem_addr, 32'h0); end
    PCSrc    = 1'b1;
    PCTarget = 32'h102;
    step();
    PCSrc = 1'b0;
    asserts++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL mis_fault: got %b expected 1", fetch_fault); end
    asserts++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mis_req: got %b expected 0", imem_req); end
    imem_gnt = 1'b1;
    step(4);
    imem_gnt = 1'b0;
    asserts++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mis_halt_req: got %b expected 0", imem_req); end
    asserts++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL mis_sticky: got %b expected 1", fetch_fault); end
    apply_reset();
    asserts++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL mis_reset_clear: got %b expected 0", fetch_fault); end
    $display("test_misaligned done: target 102");
  endtask

  task automatic test_wrap();
    step();
    PCSrc    = 1'b1;
    PCTarget = 32'hffff_fffc;
    step();
    PCSrc = 1'b0;
    asserts++; if (imem_addr !== 32'hffff_fffc) begin failures++; $display("FAIL wrap_addr: got %h expected %h", imem_addr, 32'hffff_fffc); end
    serve(32'h0000_0013);
    asserts++; if (PC !== 32'hffff_fffc) begin failures++; $display("FAIL wrap_pc: got %h expected %h", PC, 32'hffff_fffc); end
    asserts++; if (PCPlus4 !== 32'h0) begin failures++; $display("FAIL wrap_pcplus4: got %h expected %h", PCPlus4, 32'h0); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    asserts++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_addr: got %h expected %h", imem_addr, 32'h0); end
    asserts++; if (imem_req !== 1'b1) begin failures++; $display("FAIL wrap_next_req: got %b expected 1", imem_req); end
    asserts++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL wrap_fault: got %b expected 0", fetch_fault); end
    $display("test_wrap done: fffffffc -> 0");
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_timeout();
    test_misaligned();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
